sd1011_job_arbiter: RTL and testbench

Shared "1011" pattern-scan engine for multiple requesters. Each requester presents a parallel word. The block grants one requester at a time in round-robin order and shifts the granted word MSB-first through an internal overlapping Mealy 1011 detector. It then returns the match count with a one-cycle done pulse. It sits between the serial sequence-detector datapath and the client blocks that need words scanned.

---
 rtl/sd1011_job_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_sd1011_job_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd1011_job_arbiter.sv
// sd1011_job_arbiter: round-robin job arbiter feeding a shared overlapping
// Mealy "1011" detector. The granted word is shifted MSB-first. The match
// count is returned together with a one-cycle done pulse.
// Optional feature macro: SD_FIRST_POS_EN adds first_vld/first_pos, which
// report the bit index of the first completed match.
module sd1011_job_arbiter #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WORD_W-1:0]     data,
  output logic [NREQ-1:0]            gnt,
  output logic                       busy,
  output logic                       din_o,
  output logic                       dout_o,
  output logic                       done,
  output logic [$clog2(NREQ)-1:0]    done_id,
  output logic [CNT_W-1:0]           match_cnt
`ifdef SD_FIRST_POS_EN
  ,
  output logic                       first_vld,
  output logic [3:0]                 first_pos
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int BW  = $clog2(WORD_W);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  typedef enum logic [1:0] {DET_S0, DET_S1, DET_S10, DET_S101} det_t;

  state_t              state_r, state_nxt_s;
  det_t                det_r, det_nxt_s;
  logic [WORD_W-1:0]   shreg_r;
  logic [BW-1:0]       bitcnt_r;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [IDW-1:0]      last_gnt_r, winner_r, win_s;
  logic                found_s;
  logic [NREQ-1:0]     gnt_r;
  logic                busy_r, done_r;
  logic [IDW-1:0]      done_id_r;
  logic [CNT_W-1:0]    match_cnt_r;
  logic                din_s, hit_s, last_bit_s;

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign done_id   = done_id_r;
  assign match_cnt = match_cnt_r;
  assign din_o     = din_s;
  assign dout_o    = hit_s;

  assign last_bit_s = (bitcnt_r == BW'(WORD_W - 1));

  // Round-robin pick: first requesting index after the last grant, wrapping.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found_s && req[IDW'((int'(last_gnt_r) + k) % NREQ)]) begin
        found_s = 1'b1;
        win_s   = IDW'((int'(last_gnt_r) + k) % NREQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Detector input bit, next detector state and the Mealy match decode.
  always_comb begin
    din_s     = 1'b0;
    det_nxt_s = det_r;
    hit_s     = 1'b0;
    if (state_r == ST_SHIFT) begin
      din_s = shreg_r[WORD_W-1];
    end else begin
      din_s = 1'b0;
    end
    case (det_r)
      DET_S0:   det_nxt_s = din_s ? DET_S1   : DET_S0;
      DET_S1:   det_nxt_s = din_s ? DET_S1   : DET_S10;
      DET_S10:  det_nxt_s = din_s ? DET_S101 : DET_S0;
      DET_S101: det_nxt_s = din_s ? DET_S1   : DET_S10;
      default:  det_nxt_s = DET_S0;
    endcase
    if ((state_r == ST_SHIFT) && (det_r == DET_S101) && din_s) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Saturating match counter next value.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (hit_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Job FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) state_nxt_s = ST_SHIFT;
        else      state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_bit_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_SHIFT;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Job FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Job datapath: grant capture, shifting, counting and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_r       <= DET_S0;
      shreg_r     <= '0;
      bitcnt_r    <= '0;
      cnt_r       <= '0;
      last_gnt_r  <= IDW'(NREQ - 1);
      winner_r    <= '0;
      gnt_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      done_id_r   <= '0;
      match_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (|req) begin
            gnt_r    <= {{(NREQ-1){1'b0}}, 1'b1} << win_s;
            winner_r <= win_s;
            shreg_r  <= data[int'(win_s)*WORD_W +: WORD_W];
            bitcnt_r <= '0;
            cnt_r    <= '0;
            det_r    <= DET_S0;
            busy_r   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          shreg_r  <= {shreg_r[WORD_W-2:0], 1'b0};
          bitcnt_r <= bitcnt_r + {{(BW-1){1'b0}}, 1'b1};
          det_r    <= det_nxt_s;
          cnt_r    <= cnt_nxt_s;
          if (last_bit_s) begin
            gnt_r       <= '0;
            done_r      <= 1'b1;
            done_id_r   <= winner_r;
            match_cnt_r <= cnt_nxt_s;
          end
        end
        ST_DONE: begin
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          last_gnt_r <= winner_r;
        end
        default: begin
          gnt_r  <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef SD_FIRST_POS_EN
  logic       fv_r, first_vld_r;
  logic [3:0] fp_r, first_pos_r;

  assign first_vld = first_vld_r;
  assign first_pos = first_pos_r;

  // First-match tracking within a job, published alongside done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fv_r        <= 1'b0;
      fp_r        <= 4'd0;
      first_vld_r <= 1'b0;
      first_pos_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          fv_r <= 1'b0;
          fp_r <= 4'd0;
        end
        ST_SHIFT: begin
          if (hit_s && !fv_r) begin
            fv_r <= 1'b1;
            fp_r <= 4'(bitcnt_r);
          end
          if (last_bit_s) begin
            first_vld_r <= fv_r | hit_s;
            first_pos_r <= fv_r ? fp_r : (hit_s ? 4'(bitcnt_r) : 4'd0);
          end
        end
        default: begin
          fv_r <= fv_r;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sd1011_job_arbiter.sv
// Self-checking bench for sd1011_job_arbiter: random and directed jobs
// compared cycle by cycle against a job-timeline reference model.
module tb_sd1011_job_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int CW   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        busy, din_o, dout_o, done;
  logic [1:0]  done_id;
  logic [3:0]  match_cnt;

  logic [1:0]  req2;
  logic [31:0] data2;
  logic [1:0]  gnt2;
  logic        busy2, din2, dout2, done2;
  logic [0:0]  done_id2;
  logic [1:0]  match_cnt2;

`ifdef SD_FIRST_POS_EN
  logic        first_vld, first_vld2;
  logic [3:0]  first_pos, first_pos2;
`endif

  sd1011_job_arbiter #(.NREQ(NREQ), .WORD_W(W), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt), .busy(busy),
    .din_o(din_o), .dout_o(dout_o), .done(done), .done_id(done_id),
    .match_cnt(match_cnt)
`ifdef SD_FIRST_POS_EN
    , .first_vld(first_vld), .first_pos(first_pos)
`endif
  );

  sd1011_job_arbiter #(.NREQ(2), .WORD_W(16), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .req(req2), .data(data2), .gnt(gnt2), .busy(busy2),
    .din_o(din2), .dout_o(dout2), .done(done2), .done_id(done_id2),
    .match_cnt(match_cnt2)
`ifdef SD_FIRST_POS_EN
    , .first_vld(first_vld2), .first_pos(first_pos2)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: job timeline
  int          m_busy, m_p, m_win, m_last;
  logic [15:0] m_word;
  int          e_id, e_cnt, e_fv, e_fp;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int bit_at(input logic [15:0] w, input int width, input int p);
    return int'(w[width-1-p]);
  endfunction

  function automatic int hit_at(input logic [15:0] w, input int width, input int p);
    if (p < 3) return 0;
    return (bit_at(w, width, p-3) == 1 && bit_at(w, width, p-2) == 0 &&
            bit_at(w, width, p-1) == 1 && bit_at(w, width, p) == 1) ? 1 : 0;
  endfunction

  function automatic int count_hits(input logic [15:0] w, input int width, input int cw);
    int n = 0;
    for (int p = 0; p < width; p++) n += hit_at(w, width, p);
    if (n > (1 << cw) - 1) n = (1 << cw) - 1;
    return n;
  endfunction

  function automatic int first_hit(input logic [15:0] w, input int width);
    for (int p = 0; p < width; p++) if (hit_at(w, width, p) == 1) return p;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_p = 0; m_win = 0; m_last = NREQ - 1; m_word = '0;
    e_id = 0; e_cnt = 0; e_fv = 0; e_fp = 0;
  endtask

  task automatic check_all();
    int shifting;
    shifting = (m_busy == 1 && m_p < W) ? 1 : 0;
    chk("gnt",    32'(gnt),    shifting == 1 ? (32'd1 << m_win) : 32'd0);
    chk("busy",   32'(busy),   32'(m_busy));
    chk("done",   32'(done),   (m_busy == 1 && m_p == W) ? 32'd1 : 32'd0);
    chk("din_o",  32'(din_o),  shifting == 1 ? 32'(bit_at(m_word, W, m_p)) : 32'd0);
    chk("dout_o", 32'(dout_o), shifting == 1 ? 32'(hit_at(m_word, W, m_p)) : 32'd0);
    chk("done_id",   32'(done_id),   32'(e_id));
    chk("match_cnt", 32'(match_cnt), 32'(e_cnt));
`ifdef SD_FIRST_POS_EN
    chk("first_vld", 32'(first_vld), 32'(e_fv));
    chk("first_pos", 32'(first_pos), 32'(e_fp));
`endif
  endtask

  // one clock: sample inputs seen by the edge, advance the model, compare
  task automatic step();
    logic [3:0]  r;
    logic [31:0] d;
    int          f;
    r = req;
    d = data;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (m_busy == 1) begin
      m_p++;
      if (m_p == W) begin
        e_id  = m_win;
        e_cnt = count_hits(m_word, W, CW);
        f     = first_hit(m_word, W);
        e_fv  = (f >= 0) ? 1 : 0;
        e_fp  = (f >= 0) ? f : 0;
      end
      if (m_p == W + 1) begin
        m_busy = 0;
        m_last = m_win;
      end
    end else if (r != 4'd0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (m_busy == 0 && r[(m_last + k) % NREQ] == 1'b1) begin
          m_win  = (m_last + k) % NREQ;
          m_busy = 1;
        end
      end
      m_p    = 0;
      m_word = {8'h00, d[m_win*W +: W]};
    end
    #1;
    check_all();
  endtask

  logic [7:0] words [3];
  int         exp_cnt [3];
  int         exp_fp [3];
  int         n_done;
  time        t_last;
  int         seen;

  initial begin
    words[0] = 8'b1011_0110; exp_cnt[0] = 2; exp_fp[0] = 3;
    words[1] = 8'b1010_1011; exp_cnt[1] = 1; exp_fp[1] = 7;
    words[2] = 8'hFF;        exp_cnt[2] = 0; exp_fp[2] = 0;

    reset = 1'b1; req = 4'b1111; data = 32'h0; req2 = 2'b00; data2 = 32'h0;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < 3; i++) step();

    // release: first grant goes to req0, then strict rotation
    reset = 1'b0;
    step();
    chk("first_gnt", 32'(gnt), 32'd1);
    n_done = 0;
    t_last = 0;
    for (int i = 0; i < 39; i++) begin
      data = $urandom;
      step();
      if (done === 1'b1) begin
        chk("rr_id", 32'(done_id), 32'(n_done % NREQ));
        if (n_done > 0) chk("rr_gap", 32'($time - t_last), 32'd100);
        t_last = $time;
        n_done++;
      end
    end
    chk("rr_done_count", 32'(n_done), 32'd4);

    // directed words on req0, data scrambled after the grant edge
    req = 4'b0000;
    for (int i = 0; i < W + 2; i++) step();
    for (int j = 0; j < 3; j++) begin
      data = {24'h0, words[j]};
      req  = 4'b0001;
      step();
      req = 4'b0000;
      for (int i = 0; i < W; i++) begin
        data = $urandom;
        step();
      end
      chk("word_done", 32'(done), 32'd1);
      chk("word_cnt", 32'(match_cnt), 32'(exp_cnt[j]));
`ifdef SD_FIRST_POS_EN
      chk("word_fpos", 32'(first_pos), 32'(exp_fp[j]));
      chk("word_fvld", 32'(first_vld), (exp_cnt[j] > 0) ? 32'd1 : 32'd0);
`endif
      step();
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req  = 4'($urandom_range(0, 15));
      data = $urandom;
      step();
    end

    // reset in the middle of a req2 job
    req = 4'b0000;
    for (int i = 0; i < W + 2; i++) step();
    req = 4'b0100;
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      step();
      req = 4'b0000;
      if (m_busy == 1 && m_p == 4) seen = 1;
    end
    chk("mid_job_reached", 32'(seen), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    step();
    reset = 1'b0;
    req   = 4'b0101;
    step();
    chk("rst_first_gnt", 32'(gnt), 32'd1);
    req = 4'b0000;
    for (int i = 0; i < W + 2; i++) step();

    // saturating counter on the 16-bit, 2-bit-count instance
    data2 = {16'h0, 16'b1011_0110_1101_1011};
    req2  = 2'b01;
    seen  = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(posedge clk);
      #1;
      req2 = 2'b00;
      if (done2 === 1'b1) seen = 1;
    end
    chk("sat_done_seen", 32'(seen), 32'd1);
    chk("sat_cnt", 32'(match_cnt2), 32'd3);
    chk("sat_id", 32'(done_id2), 32'd0);
`ifdef SD_FIRST_POS_EN
    chk("sat_fpos", 32'(first_pos2), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
